// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with a one-entry TX holding register.
// sclk, cs_n and mosi are resynchronised into the clk domain, so sclk must
// stay at or below clk/8.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first order for
// both the TX and RX shifters. The default build shifts MSB first.
`timescale 1ns/1ps
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // state  | meaning
  // IDLE   | cs_n high, serial pins ignored, miso held at 0
  // ACTIVE | cs_n low, shifting words
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic                  sclk_s1, sclk_s2, sclk_d;
  logic                  cs_s1, cs_s2, cs_d;
  logic                  mosi_s1, mosi_s2, mosi_d;
  logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, hold_reg;
  logic                  started, armed;

  logic [DATA_WIDTH-1:0] load_val, tx_shifted, rx_next;
  logic                  load_bit, shift_bit, word_start, accept;

  // Two-flop synchronisers followed by registered edge flags.
  // mosi_d keeps the data bit aligned with the sclk_rise flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_d    <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_d      <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      mosi_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_d    <= sclk_s2;
      cs_s1     <= cs_n;
      cs_s2     <= cs_s1;
      cs_d      <= cs_s2;
      mosi_s1   <= mosi;
      mosi_s2   <= mosi_s1;
      mosi_d    <= mosi_s2;
      sclk_rise <= sclk_s2 & ~sclk_d;
      sclk_fall <= ~sclk_s2 & sclk_d;
      cs_fall   <= ~cs_s2 & cs_d;
      cs_rise   <= cs_s2 & ~cs_d;
    end
  end

  // Shift-order helpers, the next TX load value, and the word-start and handshake strobes.
  always_comb begin
    load_val   = tx_ready ? '0 : hold_reg;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    tx_shifted = {1'b0, tx_shift[DATA_WIDTH-1:1]};
    rx_next    = {mosi_d, rx_shift[DATA_WIDTH-1:1]};
    load_bit   = load_val[0];
    shift_bit  = tx_shifted[0];
`else
    tx_shifted = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_d};
    load_bit   = load_val[DATA_WIDTH-1];
    shift_bit  = tx_shifted[DATA_WIDTH-1];
`endif
    word_start = ((state == IDLE) && cs_fall && armed) ||
                 ((state == ACTIVE) && rx_valid && !cs_rise);
    accept     = tx_valid && tx_ready;
  end

  // Control FSM, TX and RX shifters, holding register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      miso     <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
      hold_reg <= '0;
      started  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      started  <= 1'b1;
      // A cs_n held low through reset must not start a transfer: wait until
      // the first synchroniser stage has sampled the pin high.
      if (started && cs_s1) armed <= 1'b1;

      // Same-cycle handshake and load while empty: the word goes out as zeros
      // and the new data waits in the holding register for the next word.
      if (word_start && !tx_ready) begin
        tx_ready <= 1'b1;
      end else if (accept) begin
        hold_reg <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            tx_shift <= load_val;
            miso     <= load_bit;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            miso    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            // The falling edge after the last bit is ignored because the next
            // word has already been loaded by then.
            if (sclk_fall && (bit_cnt != '0)) begin
              tx_shift <= tx_shifted;
              miso     <= shift_bit;
            end
            if (rx_valid) begin
              tx_shift <= load_val;
              miso     <= load_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving bits per SPI word; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, system clock; all internal state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; asynchronous, active-low reset.
REQ-004 SHALL have port sclk, input, 1, SPI serial clock from the master, asynchronous to clk.
REQ-005 SHALL have port cs_n, input, 1, SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port mosi, input, 1, master-out serial data.
REQ-007 SHALL have port miso, output, 1, slave-out serial data; always driven, never tristated.
REQ-008 SHALL have port tx_data, input, DATA_WIDTH, next word to transmit.
REQ-009 SHALL have port tx_valid, input, 1; tx_data is offered.
REQ-010 SHALL have port tx_ready, output, 1; the holding register is empty and accepts tx_data.
REQ-011 SHALL have port rx_data, output, DATA_WIDTH, last complete received word.
REQ-012 SHALL have port rx_valid, output, 1; one-clk pulse marking a new rx_data.
REQ-013 SHALL have port busy, output, 1; high while synchronized cs_n is low.

Function
REQ-014 SHALL operate in SPI mode 0: sample mosi on sclk rising edge, update miso on sclk falling edge.
REQ-015 SHALL pass sclk, cs_n and mosi through two-flop synchronizers, then a registered edge detector; sclk SHALL be at most clk/8.
REQ-016 SHALL transfer tx_data into a one-entry holding register when tx_valid and tx_ready are both high; tx_ready SHALL then be low from the next cycle until the holding register is consumed.
REQ-017 SHALL load the TX shifter at each word start (synchronized cs_n falling edge, or the cycle after the last bit of a word): from the holding register if it is full, which empties it, otherwise with all zeros.
REQ-018 SHALL drive miso with the first TX bit no later than 4 clk after the raw cs_n falling edge.
REQ-019 SHALL count received bits from 0 to DATA_WIDTH-1; on the DATA_WIDTH-th detected rising sclk edge it SHALL update rx_data, pulse rx_valid for exactly one clk, and wrap the bit counter to 0.
REQ-020 SHALL assert rx_valid in the cycle after the edge-detector output flags the final rising sclk edge; the total latency SHALL be 4 clk from the raw sclk rise.
REQ-021 SHALL, when cs_n deasserts mid-word, discard the partial word with no rx_valid, reset the bit counter, drive miso 0, and keep the holding register contents.
REQ-022 SHALL ignore sclk and mosi activity while synchronized cs_n is high.
REQ-023 SHALL, if a tx handshake and a word-start load occur in the same cycle while the holding register is empty, send zeros for the current word and retain the new tx_data for the next word.
REQ-024 SHALL use the state machine IDLE (cs_n high) -> ACTIVE (cs_n low, shifting); ACTIVE -> IDLE on synchronized cs_n rising edge; no other states.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, bit counter=0, holding register empty, and both synchronizer stages set to idle levels (sclk=0, cs_n=1).
REQ-026 SHALL resume in IDLE after reset_n release and SHALL require a fresh cs_n falling edge before shifting.

Configuration
REQ-027 SHALL support the macro SPI_SLAVE_LSB_FIRST_EN; when it is defined, both the TX and RX shift orders SHALL be LSB first, and when it is undefined, both SHALL be MSB first (default).

Verification
REQ-028 SHALL pass this scenario: DATA_WIDTH=8, MSB first; tx_data=8'hA5 loaded, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; one rx_valid with rx_data=8'h3C.
REQ-029 SHALL pass this scenario: two back-to-back words with cs_n held low, tx 8'h12 then 8'h34, master sends 8'hF0 then 8'h0F -> two rx_valid pulses (F0, 0F); miso carries 12 then 34.
REQ-030 SHALL pass this scenario: no tx handshake before cs_n falls -> miso all zeros for the word, tx_ready stays 1.
REQ-031 SHALL pass this scenario: cs_n raised after 5 bits -> no rx_valid; the next full transfer of 8'h81 yields rx_data=8'h81.
REQ-032 SHALL pass this scenario: reset_n pulsed low mid-word -> all outputs at reset values immediately; the following transfer is correct.
REQ-033 SHALL pass this scenario: SPI_SLAVE_LSB_FIRST_EN defined, tx 8'h01, master sends 8'h80 -> miso first bit 1; rx_data=8'h80.
